mem_arb: RTL
============

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter BEATS, default 8, beats per cache-line burst; power of two, 2..16.
REQ-002 SHALL have parameter STARVE_MAX, default 3, consecutive D grants allowed while I waits.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_req  in  1  instruction-side line refill request.
REQ-006 SHALL have port i_addr  in  64  refill address; low log2(BEATS)+3 bits ignored.
REQ-007 SHALL have port i_data  out  64  read beat to I side (b_rdata passthrough).
REQ-008 SHALL have port i_vld  out  1  i_data valid this cycle.
REQ-009 SHALL have port i_done  out  1  one-cycle pulse, I burst finished.
REQ-010 SHALL have ports d_req in 1, d_we in 1, d_addr in 64, d_wdata in 64: data-side request, write flag, address, write beat.
REQ-011 SHALL have ports d_rdata out 64, d_vld out 1, d_wrdy out 1, d_done out 1: read beat, read valid, write beat consumed, completion pulse.
REQ-012 SHALL have port d_lock  in  1  atomic bus lock; keeps D ownership between bursts.
REQ-013 SHALL have ports b_req out 1, b_we out 1, b_addr out 64, b_wdata out 64, b_rdata in 64, b_ack in 1: shared bus; one beat per cycle with b_ack high.
REQ-014 SHALL have ports b_rd_i out 1, b_rd_d out 1: bus currently owned by I / D side.

Function
REQ-015 SHALL implement states IDLE, BURST, DONE, LOCK.
REQ-016 IDLE: arbitrate only here; if any request, latch owner, we, line base address, go BURST next cycle.
REQ-017 Priority: D over I, except I wins when starve counter == STARVE_MAX and i_req high.
REQ-018 Starve counter: +1 (saturating) on each D grant while i_req high; cleared on I grant and reset.
REQ-019 BURST: b_req=1, b_we=latched we (I always 0), b_addr=base + beat*8, beat counter width log2(BEATS).
REQ-020 Beat counter SHALL increment only on b_ack; b_ack with counter == BEATS-1 goes to DONE, counter wraps to 0.
REQ-021 Read data SHALL pass combinationally: owner's *_vld = b_ack & BURST & !b_we; other side's vld = 0.
REQ-022 Write: b_wdata = d_wdata combinational; d_wrdy = b_ack & BURST & b_we.
REQ-023 DONE: exactly one cycle, owner's *_done=1, b_req=0, no requests sampled; next state LOCK if owner D and d_lock, else IDLE.
REQ-024 Requester SHALL drop req in DONE cycle; arbiter relies on it (req still high in next IDLE = new request).
REQ-025 LOCK: b_rd_d held, I not granted; d_req -> BURST without arbitration (starve counter unchanged); d_lock low and no d_req -> IDLE.
REQ-026 Requester req deassert or address change mid-burst SHALL be ignored; burst always completes BEATS beats.
REQ-027 b_rd_i/b_rd_d SHALL be registered, high in BURST/DONE (and LOCK for D), never both high.
REQ-028 Latency: request seen in IDLE cycle N -> b_req first high cycle N+1.

Reset
REQ-029 Reset SHALL force IDLE, beat counter 0, starve counter 0, owner none; outputs b_req, b_we, b_rd_i, b_rd_d, all vld/done/wrdy 0.
REQ-030 Reset mid-burst SHALL abandon burst immediately (no done pulse); bus slave reset together.

Structure
REQ-031 State encoding, BEATS and STARVE_MAX defaults, beat size (8 bytes) SHALL live in shared package rv6_bus_pkg.
REQ-032 Single module; no sub-module required; beat counter and starve counter inline.

Verification
REQ-033 i_req only, addr 0x1008, b_ack every cycle -> b_addr 0x1000..0x1038, 8 i_vld, i_done at cycle 10 from req.
REQ-034 i_req and d_req same cycle, d_we=1 -> D granted first, 8 d_wrdy, then I burst; b_rd_i/b_rd_d never overlap.
REQ-035 d_req held continuously (re-asserted after each done), i_req high -> I granted after exactly 3 D bursts.
REQ-036 d_lock=1 across two D bursts with i_req high -> no I grant until d_lock low; b_rd_d stays high through LOCK.
REQ-037 b_ack with gaps (1 of 3 cycles) -> b_addr holds until ack, beat count exact, done after 8th ack.
REQ-038 rst asserted at beat 4 -> next cycle b_req 0, no done; fresh i_req restarts at beat 0.

Source files
------------

// File: rtl/rv6_bus_pkg.sv
// Shared definitions for the rv6 memory-bus arbiter: FSM state and owner
// encodings, default burst geometry, and the line-base helper.
package rv6_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2,
    ST_LOCK  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int unsigned BEATS_DEFAULT      = 8;
  localparam int unsigned STARVE_MAX_DEFAULT = 3;
  localparam int unsigned BEAT_BYTES         = 8;
  localparam int unsigned BEAT_SHIFT         = 3;

  // Clears the in-line offset bits so a burst always starts on a line boundary.
  function automatic logic [63:0] line_base(input logic [63:0] addr, input int unsigned beats);
    logic [63:0] span;
    span = 64'(beats * BEAT_BYTES);
    return addr & ~(span - 64'd1);
  endfunction

endpackage

// File: rtl/mem_arb.sv
// Two-requester (I-fetch / D-cache) burst arbiter onto one shared memory bus,
// with D priority, bounded I starvation and an atomic D lock.
module mem_arb
  import rv6_bus_pkg::*;
#(
  parameter int unsigned BEATS      = BEATS_DEFAULT,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [63:0] i_addr,
  output logic [63:0] i_data,
  output logic        i_vld,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic [63:0] d_rdata,
  output logic        d_vld,
  output logic        d_wrdy,
  output logic        d_done,
  input  logic        d_lock,
  output logic        b_req,
  output logic        b_we,
  output logic [63:0] b_addr,
  output logic [63:0] b_wdata,
  input  logic [63:0] b_rdata,
  input  logic        b_ack,
  output logic        b_rd_i,
  output logic        b_rd_d
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [BW-1:0] BEAT_LAST  = BW'(BEATS - 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_e    state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          we_q, we_d;
  logic [63:0]   base_q, base_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          rd_i_q, rd_i_d;
  logic          rd_d_q, rd_d_d;
  logic          grant_d_side;
  logic          in_burst;
  logic          rd_beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_NONE;
      we_q     <= 1'b0;
      base_q   <= '0;
      beat_q   <= '0;
      starve_q <= '0;
      rd_i_q   <= 1'b0;
      rd_d_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      base_q   <= base_d;
      beat_q   <= beat_d;
      starve_q <= starve_d;
      rd_i_q   <= rd_i_d;
      rd_d_q   <= rd_d_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    base_d   = base_q;
    beat_d   = beat_q;
    starve_d = starve_q;
    // D normally wins; I takes over once D has been favoured STARVE_MAX times in a row.
    grant_d_side = d_req && !(i_req && (starve_q == STARVE_LIM));

    case (state_q)
      ST_IDLE: begin
        owner_d = OWN_NONE;
        if (grant_d_side) begin
          state_d = ST_BURST;
          owner_d = OWN_D;
          we_d    = d_we;
          base_d  = line_base(d_addr, BEATS);
          if (i_req && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + SW'(1);
          end
        end else if (i_req) begin
          state_d  = ST_BURST;
          owner_d  = OWN_I;
          we_d     = 1'b0;
          base_d   = line_base(i_addr, BEATS);
          starve_d = '0;
        end
      end
      ST_BURST: begin
        if (b_ack) begin
          beat_d = beat_q + BW'(1);
          if (beat_q == BEAT_LAST) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if ((owner_q == OWN_D) && d_lock) begin
          state_d = ST_LOCK;
        end else begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end
      end
      ST_LOCK: begin
        // Locked D bursts bypass arbitration and leave the starve count alone.
        if (d_req) begin
          state_d = ST_BURST;
          we_d    = d_we;
          base_d  = line_base(d_addr, BEATS);
        end else if (!d_lock) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase

    rd_i_d = (owner_d == OWN_I) && ((state_d == ST_BURST) || (state_d == ST_DONE));
    rd_d_d = (owner_d == OWN_D) && (state_d != ST_IDLE);
  end

  always_comb begin
    in_burst = (state_q == ST_BURST);
    rd_beat  = b_ack && in_burst && !we_q;
    b_req    = in_burst;
    b_we     = in_burst && we_q;
    b_addr   = in_burst ? (base_q + (64'(beat_q) << BEAT_SHIFT)) : '0;
    b_wdata  = d_wdata;
    i_data   = b_rdata;
    d_rdata  = b_rdata;
    i_vld    = rd_beat && (owner_q == OWN_I);
    d_vld    = rd_beat && (owner_q == OWN_D);
    d_wrdy   = b_ack && in_burst && we_q;
    i_done   = (state_q == ST_DONE) && (owner_q == OWN_I);
    d_done   = (state_q == ST_DONE) && (owner_q == OWN_D);
    b_rd_i   = rd_i_q;
    b_rd_d   = rd_d_q;
  end

endmodule
